fetch_queue: RTL and testbench

- Parametrised successor to the single-shot fetch stage.
- Continuously prefetches sequential instruction words from a fixed-latency synchronous memory into a DEPTH-entry queue.
- Hands instructions to decode over a valid/ack handshake.
- Supports redirect (branch/jump) with queue flush.
- Sits between the program memory port and the decode/execute sequencer.

---
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// Sequential instruction prefetcher feeding a DEPTH-entry {pc, word} queue; one read outstanding.
// Optional starvation counter on stall_cnt is built only when FETCH_STALL_CNT_EN is defined.
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int MEM_LAT = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              ack,
  output logic [15:0]       stall_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fpc;
  logic [2:0]        wcnt;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count, count_nxt;
  logic              push, pop;

  assign valid    = (count != '0);
  assign inst_out = dat_q[head];
  assign inst_pc  = pc_q[head];
  assign push     = (state == CAPTURE) && !redirect;
  assign pop      = valid && ack && !redirect;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // No read is in flight while IDLE, so free space is judged on the post-pop occupancy alone.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && (count_nxt < CW'(DEPTH))) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LAT == 1) ? CAPTURE : WAIT;
      WAIT:    if (wcnt <= 3'd1) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (en && (count_nxt < CW'(DEPTH))) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      wcnt     <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      mem_rd <= (state_nxt == ISSUE);
      // mem_addr holds through WAIT/CAPTURE and doubles as the pc of the word being captured.
      if (state_nxt == ISSUE) mem_addr <= fpc;
      if (redirect) begin
        fpc   <= redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (state == ISSUE) begin
          fpc  <= fpc + 1'b1;
          wcnt <= 3'(MEM_LAT - 1);
        end else if (state == WAIT) begin
          wcnt <= wcnt - 3'd1;
        end
        if (push) begin
          pc_q[tail]  <= mem_addr;
          dat_q[tail] <= mem_data;
          tail        <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count_nxt;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (en && !valid && !redirect && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// Bench for fetch_queue: memory model returns addr^0xA5 after MEM_LAT cycles; scoreboard checks pop order.
module tb_fetch_queue;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       valid;
  logic [7:0] inst_out;
  logic [7:0] inst_pc;
  logic       ack = 1'b0;
  logic [15:0] stall_cnt;

  int compared = 0;
  int mismatched = 0;
  int npop = 0;
  int stall_exp = 0;
  logic [15:0] exp_q[$];

  logic       rd_pipe [LAT];
  logic [7:0] ad_pipe [LAT];

  fetch_queue #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .MEM_LAT(LAT), .RESET_PC(8'h10)) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .valid(valid), .inst_out(inst_out), .inst_pc(inst_pc), .ack(ack), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        rd_pipe[i] <= 1'b0;
        ad_pipe[i] <= 8'h00;
      end
    end else begin
      rd_pipe[0] <= mem_rd;
      ad_pipe[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
        ad_pipe[i] <= ad_pipe[i-1];
      end
    end
  end

  assign mem_data = rd_pipe[LAT-1] ? (ad_pipe[LAT-1] ^ 8'hA5) : 8'hEE;

  // Scoreboard: expected {pc, word} pushed on each read issue, popped on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_exp = 0;
    end else begin
      if (en && !valid && !redirect && stall_exp < 65535) stall_exp++;
      if (mem_rd) exp_q.push_back({mem_addr, mem_addr ^ 8'hA5});
      if (valid && ack && !redirect) begin
        logic [15:0] e;
        compared++;
        npop++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL pop_unexpected: got pc=%h data=%h, expected no pop", inst_pc, inst_out);
        end else begin
          e = exp_q.pop_front();
          if ({inst_pc, inst_out} !== e) begin
            mismatched++;
            $display("FAIL pop_order: got pc=%h data=%h, expected pc=%h data=%h",
                     inst_pc, inst_out, e[15:8], e[7:0]);
          end
        end
      end
      if (redirect) exp_q.delete();
    end
  end

  task automatic pulse_redirect(input logic [7:0] pc);
    redirect_pc = pc;
    redirect = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (mem_rd !== 1'b0) begin mismatched++; $display("FAIL reset_mem_rd: got %b, expected 0", mem_rd); end
    compared++; if (mem_addr !== 8'h00) begin mismatched++; $display("FAIL reset_mem_addr: got %h, expected 00", mem_addr); end
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b, expected 0", valid); end
    compared++; if (inst_out !== 8'h00) begin mismatched++; $display("FAIL reset_inst_out: got %h, expected 00", inst_out); end
    compared++; if (inst_pc !== 8'h00) begin mismatched++; $display("FAIL reset_inst_pc: got %h, expected 00", inst_pc); end
    compared++; if (stall_cnt !== 16'h0000) begin mismatched++; $display("FAIL reset_stall_cnt: got %h, expected 0000", stall_cnt); end
  endtask

  task automatic test_fill;
    logic [7:0] ra [8];
    int rc [8];
    int n = 0;
    int vcyc = -1;
    int sexp;
    en = 1'b1; ack = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mem_rd && n < 8) begin ra[n] = mem_addr; rc[n] = i; n++; end
      if (valid && vcyc < 0) vcyc = i;
    end
    compared++; if (n !== 4) begin mismatched++; $display("FAIL fill_read_count: got %0d, expected 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      compared++;
      if (ra[k] !== 8'(8'h10 + k)) begin mismatched++; $display("FAIL fill_addr%0d: got %h, expected %h", k, ra[k], 8'(8'h10 + k)); end
      if (k > 0) begin
        compared++;
        if (rc[k] - rc[k-1] !== LAT + 1) begin mismatched++; $display("FAIL fill_spacing%0d: got %0d, expected %0d", k, rc[k] - rc[k-1], LAT + 1); end
      end
    end
    if (n > 0) begin
      compared++;
      if (vcyc - rc[0] !== LAT + 1) begin mismatched++; $display("FAIL fill_valid_latency: got %0d, expected %0d", vcyc - rc[0], LAT + 1); end
    end
    compared++; if (mem_rd !== 1'b0) begin mismatched++; $display("FAIL fill_full_rd: got %b, expected 0", mem_rd); end
    compared++; if (inst_pc !== 8'h10) begin mismatched++; $display("FAIL fill_head_pc: got %h, expected 10", inst_pc); end
    compared++; if (inst_out !== 8'hB5) begin mismatched++; $display("FAIL fill_head_data: got %h, expected b5", inst_out); end
`ifdef FETCH_STALL_CNT_EN
    sexp = stall_exp;
`else
    sexp = 0;
`endif
    compared++; if (stall_cnt !== 16'(sexp)) begin mismatched++; $display("FAIL fill_stall_cnt: got %0d, expected %0d", stall_cnt, sexp); end
  endtask

  task automatic test_drain;
    int p0 = npop;
    ack = 1'b1;
    @(posedge clk); #1;
    compared++; if (mem_rd !== 1'b1 || mem_addr !== 8'h14) begin mismatched++; $display("FAIL drain_refill: got rd=%b addr=%h, expected rd=1 addr=14", mem_rd, mem_addr); end
    repeat (3) @(posedge clk);
    #1;
    ack = 1'b0;
    compared++; if (npop - p0 !== 4) begin mismatched++; $display("FAIL drain_pops: got %0d, expected 4", npop - p0); end
  endtask

  task automatic test_redirect;
    bit found = 0;
    ack = 1'b0;
    pulse_redirect(8'h02);
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_rd && mem_addr == 8'h05) found = 1;
      else begin @(posedge clk); #1; end
    end
    compared++; if (!found) begin mismatched++; $display("FAIL redir_wait_05: got timeout, expected read of 05"); end
    @(posedge clk); #1;
    compared++; if (valid !== 1'b1) begin mismatched++; $display("FAIL redir_pre_valid: got %b, expected 1", valid); end
    redirect_pc = 8'h40; redirect = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0; ack = 1'b0;
    compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL redir_flush: got valid=%b, expected 0", valid); end
    @(posedge clk); #1;
    compared++; if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin mismatched++; $display("FAIL redir_issue: got rd=%b addr=%h, expected rd=1 addr=40", mem_rd, mem_addr); end
    ack = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    compared++;
    if (!found || inst_pc !== 8'h40 || inst_out !== 8'hE5) begin
      mismatched++; $display("FAIL redir_first_pop: got valid=%b pc=%h data=%h, expected pc=40 data=e5", valid, inst_pc, inst_out);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap;
    logic [7:0] ra [8];
    logic [7:0] pp [8];
    logic [7:0] want [4];
    int n = 0;
    int m = 0;
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    ack = 1'b0;
    pulse_redirect(8'hFE);
    for (int i = 0; i < 20; i++) begin
      if (mem_rd && n < 8) begin ra[n] = mem_addr; n++; end
      @(posedge clk); #1;
    end
    compared++; if (n !== 4) begin mismatched++; $display("FAIL wrap_count: got %0d, expected 4", n); end
    ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (valid && m < 8) begin pp[m] = inst_pc; m++; end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (k >= n || ra[k] !== want[k]) begin mismatched++; $display("FAIL wrap_addr%0d: got %h, expected %h", k, (k < n) ? ra[k] : 8'hxx, want[k]); end
      compared++;
      if (k >= m || pp[k] !== want[k]) begin mismatched++; $display("FAIL wrap_pc%0d: got %h, expected %h", k, (k < m) ? pp[k] : 8'hxx, want[k]); end
    end
  endtask

  task automatic test_en_drop;
    bit found = 0;
    int nrd = 0;
    int got = 0;
    ack = 1'b1;
    pulse_redirect(8'h20);
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_rd && mem_addr == 8'h20) found = 1;
      else begin @(posedge clk); #1; end
    end
    compared++; if (!found) begin mismatched++; $display("FAIL endrop_wait_20: got timeout, expected read of 20"); end
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_rd) nrd++;
      if (valid) begin
        got++;
        compared++;
        if (inst_pc !== 8'h20 || inst_out !== 8'h85) begin mismatched++; $display("FAIL endrop_word: got pc=%h data=%h, expected pc=20 data=85", inst_pc, inst_out); end
      end
      @(posedge clk); #1;
    end
    compared++; if (nrd !== 0) begin mismatched++; $display("FAIL endrop_no_rd: got %0d reads, expected 0", nrd); end
    compared++; if (got !== 1) begin mismatched++; $display("FAIL endrop_queued: got %0d valid cycles, expected 1", got); end
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_rd) found = 1;
    end
    compared++; if (!found || mem_addr !== 8'h21) begin mismatched++; $display("FAIL endrop_resume: got rd=%b addr=%h, expected rd=1 addr=21", mem_rd, mem_addr); end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_stall_final;
    int sexp;
`ifdef FETCH_STALL_CNT_EN
    sexp = stall_exp;
`else
    sexp = 0;
`endif
    compared++; if (stall_cnt !== 16'(sexp)) begin mismatched++; $display("FAIL final_stall_cnt: got %0d, expected %0d", stall_cnt, sexp); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_redirect();
    test_wrap();
    test_en_drop();
    test_stall_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
